// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - LEGv8 instruction fetch stage: PC, IF/ID register, stall/redirect/halt
module inst_fetch #(
   parameter int               WORD      = 64,
   parameter int               INST_SIZE = 32,
   parameter logic [WORD-1:0]  RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 halt,
   input  logic                 stall,
   input  logic                 br_taken,
   input  logic [WORD-1:0]      br_target,
   input  logic [INST_SIZE-1:0] inst,
   output logic [WORD-1:0]      pc,
   output logic [WORD-1:0]      if_id_pc,
   output logic [INST_SIZE-1:0] if_id_inst,
   output logic                 if_id_valid,
   output logic [31:0]          fetch_cnt,
   output logic                 align_err,
   output logic                 running
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t state;

   // Fetch FSM: control state, PC and the IF/ID register all move together on one edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         if_id_pc    <= '0;
         if_id_inst  <= '0;
         if_id_valid <= 1'b0;
         fetch_cnt   <= '0;
         align_err   <= 1'b0;
         running     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // halt wins over start so a core told to stop never issues a fetch
               if (halt) begin
                  state   <= HALT;
                  running <= 1'b0;
               end else if (start) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (halt) begin
                  state       <= HALT;
                  running     <= 1'b0;
                  if_id_valid <= 1'b0;
                  if_id_inst  <= '0;
               end else if (br_taken) begin
                  // redirect beats stall: the flushed slot is a bubble anyway
                  pc          <= {br_target[WORD-1:2], 2'b00};
                  if_id_valid <= 1'b0;
                  if_id_inst  <= '0;
                  if (br_target[1:0] != 2'b00) begin
                     align_err <= 1'b1;
                  end
               end else if (!stall) begin
                  if_id_pc    <= pc;
                  if_id_inst  <= inst;
                  if_id_valid <= 1'b1;
                  pc          <= pc + WORD'(4);
                  fetch_cnt   <= fetch_cnt + 32'd1;
               end
            end
            HALT: begin
               if_id_valid <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst, start, halt, stall, br_taken;
   logic [63:0] br_target;
   logic [31:0] inst;
   logic [63:0] pc, if_id_pc;
   logic [31:0] if_id_inst, fetch_cnt;
   logic        if_id_valid, align_err, running;

   logic        rst2, start2, zero1;
   logic [63:0] zero64;
   logic [31:0] inst2;
   logic [63:0] pc2, if_id_pc2;
   logic [31:0] if_id_inst2, fetch_cnt2;
   logic        if_id_valid2, align_err2, running2;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // instruction memory image: word k holds k
   assign inst = 32'(pc / 4);

   inst_fetch #(.RESET_PC(64'd0)) dut (
      .clk(clk), .rst(rst), .start(start), .halt(halt), .stall(stall),
      .br_taken(br_taken), .br_target(br_target), .inst(inst),
      .pc(pc), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
      .if_id_valid(if_id_valid), .fetch_cnt(fetch_cnt),
      .align_err(align_err), .running(running)
   );

   inst_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut2 (
      .clk(clk), .rst(rst2), .start(start2), .halt(zero1), .stall(zero1),
      .br_taken(zero1), .br_target(zero64), .inst(inst2),
      .pc(pc2), .if_id_pc(if_id_pc2), .if_id_inst(if_id_inst2),
      .if_id_valid(if_id_valid2), .fetch_cnt(fetch_cnt2),
      .align_err(align_err2), .running(running2)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // behavioural model: mode 0 idle, 1 run, 2 halted
   int          m_mode;
   logic [63:0] m_pc, m_ipc;
   logic [31:0] m_inst, m_cnt;
   logic        m_valid, m_align;

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0; m_pc = 64'd0; m_ipc = 64'd0; m_inst = 32'd0;
         m_valid = 1'b0; m_cnt = 32'd0; m_align = 1'b0;
      end else if (m_mode == 0) begin
         if (halt) m_mode = 2;
         else if (start) m_mode = 1;
      end else if (m_mode == 1) begin
         if (halt) begin
            m_mode = 2; m_valid = 1'b0; m_inst = 32'd0;
         end else if (br_taken) begin
            m_pc = br_target - (br_target % 4);
            m_valid = 1'b0; m_inst = 32'd0;
            if (br_target % 4 != 0) m_align = 1'b1;
         end else if (!stall) begin
            m_ipc = m_pc; m_inst = 32'(m_pc / 4); m_valid = 1'b1;
            m_pc = m_pc + 64'd4; m_cnt = m_cnt + 32'd1;
         end
      end else begin
         m_valid = 1'b0;
      end
   end

   // compare every cycle, away from the active edge
   always @(negedge clk) begin
      check("pc", pc, m_pc);
      check("if_id_valid", 64'(if_id_valid), 64'(m_valid));
      check("if_id_inst", 64'(if_id_inst), 64'(m_inst));
      check("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
      check("align_err", 64'(align_err), 64'(m_align));
      check("running", 64'(running), 64'(m_mode == 1));
      if (m_valid) check("if_id_pc", if_id_pc, m_ipc);
   end

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst = 1; start = 0; halt = 0; stall = 0; br_taken = 0; br_target = '0;
      rst2 = 1; start2 = 0; zero1 = 0; zero64 = '0; inst2 = '0;
      step(); step();
      check("rst pc", pc, 64'd0);
      check("rst if_id_pc", if_id_pc, 64'd0);
      check("rst valid", 64'(if_id_valid), 64'd0);
      check("rst cnt", 64'(fetch_cnt), 64'd0);
      check("rst running", 64'(running), 64'd0);

      rst = 0; start = 1; step();
      check("start running", 64'(running), 64'd1);
      check("start valid", 64'(if_id_valid), 64'd0);
      start = 0;
      repeat (10) step();
      check("run10 cnt", 64'(fetch_cnt), 64'd10);
      check("run10 pc", pc, 64'd40);
      check("run10 inst", 64'(if_id_inst), 64'd9);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall pc", pc, 64'd40);
         check("stall inst", 64'(if_id_inst), 64'd9);
         check("stall cnt", 64'(fetch_cnt), 64'd10);
      end
      stall = 0; step();
      check("post-stall inst", 64'(if_id_inst), 64'd10);
      check("post-stall cnt", 64'(fetch_cnt), 64'd11);
      repeat (53) step();
      check("run64 cnt", 64'(fetch_cnt), 64'd64);
      check("run64 pc", pc, 64'd256);

      stall = 1; br_taken = 1; br_target = 64'h80; step();
      check("br80 pc", pc, 64'h80);
      check("br80 bubble", 64'(if_id_valid), 64'd0);
      stall = 0; br_taken = 0; step();
      check("br80 inst", 64'(if_id_inst), 64'd32);
      check("br80 if_id_pc", if_id_pc, 64'h80);
      check("br80 align", 64'(align_err), 64'd0);

      br_taken = 1; br_target = 64'h46; step();
      check("br46 pc", pc, 64'h44);
      check("br46 align", 64'(align_err), 64'd1);
      br_taken = 0; step();
      check("br46 inst", 64'(if_id_inst), 64'd17);
      repeat (2) step();
      check("align sticky", 64'(align_err), 64'd1);
      check("pre-halt pc", pc, 64'h50);

      halt = 1; step();
      check("halt running", 64'(running), 64'd0);
      check("halt valid", 64'(if_id_valid), 64'd0);
      halt = 0; start = 1; br_taken = 1; br_target = 64'h100; stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("halted pc", pc, 64'h50);
         check("halted running", 64'(running), 64'd0);
         check("halted cnt", 64'(fetch_cnt), 64'd68);
      end
      br_taken = 0; stall = 0; rst = 1; step();
      check("rst-over-start running", 64'(running), 64'd0);
      check("rst2 pc", pc, 64'd0);
      check("rst2 cnt", 64'(fetch_cnt), 64'd0);
      check("rst2 align", 64'(align_err), 64'd0);

      rst = 0; halt = 1; start = 1; step();
      check("idle halt prio", 64'(running), 64'd0);
      halt = 0; start = 0; step();
      check("halt sticky", 64'(running), 64'd0);
      rst = 1; step();
      rst = 0; start = 1; step();
      start = 0; step();
      check("restart inst", 64'(if_id_inst), 64'd0);
      check("restart valid", 64'(if_id_valid), 64'd1);
      check("restart pc", pc, 64'd4);

      rst2 = 0; start2 = 1; step();
      check("w pc0", pc2, 64'hFFFF_FFFF_FFFF_FFF8);
      start2 = 0; inst2 = 32'h11; step();
      check("w pc1", pc2, 64'hFFFF_FFFF_FFFF_FFFC);
      check("w ipc1", if_id_pc2, 64'hFFFF_FFFF_FFFF_FFF8);
      check("w inst1", 64'(if_id_inst2), 64'h11);
      inst2 = 32'h22; step();
      check("w pc2", pc2, 64'd0);
      check("w ipc2", if_id_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
      inst2 = 32'h33; step();
      check("w pc3", pc2, 64'd4);
      check("w ipc3", if_id_pc2, 64'd0);
      check("w inst3", 64'(if_id_inst2), 64'h33);
      check("w cnt", 64'(fetch_cnt2), 64'd3);
      check("w valid", 64'(if_id_valid2), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the LEGv8 core: the initiator side of the instruction-memory interface. Owns the program counter, drives `pc` into `inst_mem`, captures the returned combinational `inst` into the IF/ID pipeline register, and handles stall, branch redirect and halt. Sits between the core control and `inst_mem`, with its IF/ID outputs feeding decode.

## Interface
- `RESET_PC`, 64'd0, PC value loaded on reset; must be word-aligned.
- `clk`  in  1  core clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle pulse; leaves IDLE and begins fetching.
- `halt`  in  1  stop fetching; sticky until `rst`.
- `stall`  in  1  hold PC and IF/ID register (decode back-pressure).
- `br_taken`  in  1  redirect request from a later stage.
- `br_target`  in  `WORD` (64)  redirect address.
- `inst`  in  `INST_SIZE` (32)  instruction word returned by `inst_mem` for current `pc`, same cycle.
- `pc`  out  `WORD`  fetch address to `inst_mem`; register output.
- `if_id_pc`  out  `WORD`  PC of the captured instruction.
- `if_id_inst`  out  `INST_SIZE`  captured instruction; 0 when invalid.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `fetch_cnt`  out  32  number of instructions captured since reset.
- `align_err`  out  1  sticky: a redirect target had `br_target[1:0] != 0`.
- `running`  out  1  high in state RUN.

## Operation
- States: IDLE, RUN, HALT. Reset state IDLE.
- IDLE: `pc` held at `RESET_PC`, `if_id_valid`=0. `start`=1 -> RUN next cycle. `halt`=1 in IDLE -> HALT (halt has priority over start).
- RUN, per posedge, priority order:
  1. `halt`: -> HALT; `if_id_valid`<=0, `if_id_inst`<=0; `pc` held.
  2. `br_taken`: `pc`<={`br_target`[63:2],2'b00}; `if_id_valid`<=0, `if_id_inst`<=0 (flush); `align_err`<=1 if `br_target`[1:0]!=0. The redirect is honoured even when `stall`=1.
  3. `stall`: all registers hold.
  4. Otherwise: `if_id_pc`<=`pc`, `if_id_inst`<=`inst`, `if_id_valid`<=1, `pc`<=`pc`+4, `fetch_cnt`<=`fetch_cnt`+1.
- HALT: all registers hold except `if_id_valid`=0; only `rst` exits.
- `br_taken` / `stall` in IDLE or HALT: ignored.
- Arithmetic: `pc`+4 is modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC -> 0). `fetch_cnt` wraps 0xFFFF_FFFF -> 0.
- `if_id_pc` is not cleared on flush; it is only meaningful when `if_id_valid`=1.

## Timing
- Reset values (after a posedge with `rst`=1): `pc`=`RESET_PC`, `if_id_pc`=0, `if_id_inst`=0, `if_id_valid`=0, `fetch_cnt`=0, `align_err`=0, `running`=0, state IDLE.
- `rst` overrides everything, including a redirect or start in the same cycle; reset mid-RUN discards the IF/ID contents.
- `start` sampled at edge N -> `running`=1 after N. The first capture happens at edge N+1 (instruction at `RESET_PC`), so `if_id_valid`=1 after N+1.
- Fetch latency is one cycle: the `inst` presented for `pc` at edge K appears on `if_id_inst` after edge K.
- Redirect: `br_taken` at edge K -> `pc`=target after K, bubble (`if_id_valid`=0) after K, target instruction valid after K+1.
- Sustained throughput is one instruction per cycle with no stall or redirect.
- `inst_mem` must be combinational; no wait states are supported.

## Test plan
Memory file holds word k = k (same image as the `inst_mem` bench); `RESET_PC`=0.
- Reset, then `start` pulse, then 64 free-running cycles -> after each edge `if_id_inst`==`if_id_pc`/4 and `if_id_valid`=1; `fetch_cnt`=64 at the end; `pc`=256.
- Stall for 3 cycles when `pc`=40 -> `pc`, `if_id_inst`=9 and `fetch_cnt` frozen for 3 cycles; the next capture is 10 with no skip and no duplicate.
- `br_taken` with `br_target`=0x80 while `stall`=1 -> one bubble, then `if_id_inst`=32, `if_id_pc`=0x80; `align_err`=0.
- `br_taken` with `br_target`=0x46 -> `pc`=0x44, `if_id_inst`=17 after the bubble; `align_err`=1 and stays 1 until `rst`.
- `halt` asserted in RUN -> `running`=0 and `if_id_valid`=0 next cycle; `start`, `br_taken` and `stall` ignored; `rst` returns the block to IDLE with all reset values.
- `RESET_PC`=64'hFFFF_FFFF_FFFF_FFF8, drive `inst` directly from the bench, run 3 captures -> `pc` sequence FFF8, FFFC, 0, 4 (wraps cleanly).
